// File: rtl/button_conditioner.sv
// Synchronise, debounce and mutually exclude the increase/decrease buttons.
// Held levels feed the controller; one-cycle pulses mark accepted presses.
module button_debounce #(
   parameter int DEB_CYCLES = 1000000,
   parameter int CNT_W      = 20
) (
   input  logic clk_i,
   input  logic reset,
   input  logic s_i,
   output logic deb_o
);
   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (s_i) begin
               state_nx = PRESS_WAIT;
               cnt_nx   = ONE;
            end
         end
         PRESS_WAIT: begin
            if (!s_i) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == LAST) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         PRESSED: begin
            if (!s_i) begin
               state_nx = RELEASE_WAIT;
               cnt_nx   = ONE;
            end
         end
         RELEASE_WAIT: begin
            if (s_i) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
            end else if (cnt == LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_comb begin
      deb_o = (state == PRESSED) || (state == RELEASE_WAIT);
   end
endmodule

module button_conditioner #(
   parameter int DEB_CYCLES = 1000000,
   parameter int CNT_W      = 20
) (
   input  logic clk_i,
   input  logic reset,
   input  logic aum_btn_i,
   input  logic baja_btn_i,
   output logic aumC_o,
   output logic bajaC_o,
   output logic aum_press_o,
   output logic baja_press_o
);
   logic aum_s1, aum_s2;
   logic baja_s1, baja_s2;
   logic aum_deb, baja_deb;
   logic aum_nx, baja_nx;

   always_ff @(posedge clk_i) begin
      if (reset) begin
         aum_s1  <= 1'b0;
         aum_s2  <= 1'b0;
         baja_s1 <= 1'b0;
         baja_s2 <= 1'b0;
      end else begin
         aum_s1  <= aum_btn_i;
         aum_s2  <= aum_s1;
         baja_s1 <= baja_btn_i;
         baja_s2 <= baja_s1;
      end
   end

   button_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
   ) u_aum (
      .clk_i(clk_i),
      .reset(reset),
      .s_i  (aum_s2),
      .deb_o(aum_deb)
   );

   button_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
   ) u_baja (
      .clk_i(clk_i),
      .reset(reset),
      .s_i  (baja_s2),
      .deb_o(baja_deb)
   );

   // Pulses compare the next exclusive level against the current one, so a
   // simultaneous rise of both buttons (next level 0) never pulses.
   assign aum_nx  = aum_deb & ~baja_deb;
   assign baja_nx = baja_deb & ~aum_deb;

   always_ff @(posedge clk_i) begin
      if (reset) begin
         aumC_o       <= 1'b0;
         bajaC_o      <= 1'b0;
         aum_press_o  <= 1'b0;
         baja_press_o <= 1'b0;
      end else begin
         aumC_o       <= aum_nx;
         bajaC_o      <= baja_nx;
         aum_press_o  <= aum_nx & ~aumC_o;
         baja_press_o <= baja_nx & ~bajaC_o;
      end
   end
endmodule

// File: tb/tb_button_conditioner.sv
// Random and directed bench for button_conditioner against a sample-window
// reference model: a level is accepted after DEB consecutive differing samples.
module tb_button_conditioner;
   localparam int DEB = 4;

   logic clk_i = 1'b0;
   logic reset = 1'b1;
   logic aum_btn_i = 1'b0;
   logic baja_btn_i = 1'b0;
   logic aumC_o, bajaC_o, aum_press_o, baja_press_o;

   int compared = 0;
   int mismatched = 0;

   // reference model state
   bit d1[2], d2[2];
   bit win[2][DEB];
   bit deb[2];
   bit e_lvl[2], e_prs[2];
   int pcnt_a, pcnt_b;

   button_conditioner #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
      .clk_i       (clk_i),
      .reset       (reset),
      .aum_btn_i   (aum_btn_i),
      .baja_btn_i  (baja_btn_i),
      .aumC_o      (aumC_o),
      .bajaC_o     (bajaC_o),
      .aum_press_o (aum_press_o),
      .baja_press_o(baja_press_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic got, input logic exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int got, input int exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit accept(input int i);
      for (int j = 0; j < DEB; j++)
         if (win[i][j] == deb[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge(input bit a, input bit b, input bit r);
      bit raw[2];
      bit seen;
      bit nl[2];
      raw[0] = a;
      raw[1] = b;
      if (r) begin
         for (int i = 0; i < 2; i++) begin
            d1[i] = 0; d2[i] = 0; deb[i] = 0;
            e_lvl[i] = 0; e_prs[i] = 0;
            for (int j = 0; j < DEB; j++) win[i][j] = 0;
         end
         return;
      end
      nl[0] = deb[0] & ~deb[1];
      nl[1] = deb[1] & ~deb[0];
      for (int i = 0; i < 2; i++) begin
         e_prs[i] = nl[i] & ~e_lvl[i];
         e_lvl[i] = nl[i];
         seen = d2[i];
         d2[i] = d1[i];
         d1[i] = raw[i];
         for (int j = 0; j < DEB - 1; j++) win[i][j] = win[i][j+1];
         win[i][DEB-1] = seen;
         if (accept(i)) deb[i] = ~deb[i];
      end
   endtask

   task automatic step(input bit a, input bit b, input bit r);
      aum_btn_i = a;
      baja_btn_i = b;
      reset = r;
      @(posedge clk_i);
      model_edge(a, b, r);
      #1;
      chk("aumC", aumC_o, e_lvl[0]);
      chk("bajaC", bajaC_o, e_lvl[1]);
      chk("aum_press", aum_press_o, e_prs[0]);
      chk("baja_press", baja_press_o, e_prs[1]);
      if (aum_press_o === 1'b1) pcnt_a++;
      if (baja_press_o === 1'b1) pcnt_b++;
   endtask

   task automatic run(input bit a, input bit b, input int n);
      for (int i = 0; i < n; i++) step(a, b, 0);
   endtask

   initial begin
      // reset then idle
      for (int i = 0; i < 3; i++) step(0, 0, 1);
      chk("rst_aumC", aumC_o, 1'b0);
      chk("rst_bajaC", bajaC_o, 1'b0);
      run(0, 0, 6);

      // clean press/release, explicit latency
      pcnt_a = 0; pcnt_b = 0;
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 0);
         if (i == DEB + 1) chk("lat_pre", aumC_o, 1'b0);
         if (i == DEB + 2) chk("lat_rise", aumC_o, 1'b1);
         if (i == DEB + 2) chk("lat_pulse", aum_press_o, 1'b1);
      end
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0);
         if (i == DEB + 1) chk("rel_pre", aumC_o, 1'b1);
         if (i == DEB + 2) chk("rel_fall", aumC_o, 1'b0);
      end
      chk_int("clean_pulses", pcnt_a, 1);

      // bounce reject then stable press
      pcnt_a = 0;
      step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
      step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
      step(1, 0, 0);
      run(0, 0, 8);
      chk_int("bounce_pulses", pcnt_a, 0);
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0);
         if (i == DEB + 2) chk("bounce_rise", aumC_o, 1'b1);
      end
      run(0, 0, 10);
      chk_int("bounce_pulses2", pcnt_a, 1);

      // mutual exclusion
      pcnt_a = 0; pcnt_b = 0;
      run(1, 0, 10);
      run(1, 1, 10);
      chk("mx_aum", aumC_o, 1'b0);
      chk("mx_baja", bajaC_o, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0);
         if (i == DEB + 2) chk("mx_return", aumC_o, 1'b1);
      end
      chk_int("mx_aum_pulses", pcnt_a, 2);
      chk_int("mx_baja_pulses", pcnt_b, 0);
      run(0, 0, 10);

      // simultaneous press
      pcnt_a = 0; pcnt_b = 0;
      run(1, 1, 12);
      chk_int("sim_pulses", pcnt_a + pcnt_b, 0);
      run(1, 0, 10);
      chk("sim_aum", aumC_o, 1'b1);
      chk_int("sim_aum_pulses", pcnt_a, 1);
      chk_int("sim_baja_pulses", pcnt_b, 0);
      run(0, 0, 10);

      // reset mid-press, button held throughout
      pcnt_a = 0;
      run(1, 0, DEB + 5);
      step(1, 0, 1);
      chk("rst_mid", aumC_o, 1'b0);
      step(1, 0, 1);
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0);
         if (i == DEB + 1) chk("rst_re_pre", aumC_o, 1'b0);
         if (i == DEB + 2) chk("rst_re_rise", aumC_o, 1'b1);
      end
      chk_int("rst_pulses", pcnt_a, 2);
      run(0, 0, 10);

      // random bursts, including short glitches and overlaps
      for (int k = 0; k < 150; k++) begin
         bit a, b, r;
         int n;
         a = 1'($urandom_range(0, 1));
         b = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 39) == 0);
         n = $urandom_range(1, 2 * DEB + 4);
         for (int i = 0; i < n; i++) step(a, b, r && (i == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end
endmodule
